mk_sized_fifo: RTL
==================

// Module: mk_sized_fifo
// PURPOSE
// - Parametrised FIFO of `depth` entries, each `width` bits wide; the buffered successor of the single-entry register primitives.
// - Sits between producer and consumer rules wherever one-deep register storage is not enough.
// - Provides enqueue/dequeue strobes, full/empty flags, an occupancy count and a synchronous clear.
// - Optional pipelined mode: accepts an enqueue while full if a dequeue happens in the same cycle.
// PARAMETERS
// width     1  data bits per entry; width==0 is legal, data ports are then 1 bit and carry 0
// depth     2  number of entries, >=1
// pipelined 0  1: enq accepted when full if IN_EN_DEQ is asserted in the same cycle; 0: enq ignored when full
// PORTS
// CLK          in   1              clock, all state updates on posedge
// RST_N        in   1              asynchronous active-low reset
// IN_ENQ       in   max(width,1)   data to enqueue
// IN_EN_ENQ    in   1              enqueue strobe
// IN_EN_DEQ    in   1              dequeue strobe
// IN_EN_CLEAR  in   1              synchronous clear strobe
// OUT_FIRST    out  max(width,1)   head entry; 0 when empty
// OUT_NOTFULL  out  1              1 when count < depth
// OUT_NOTEMPTY out  1              1 when count > 0
// OUT_COUNT    out  $clog2(depth+1) current occupancy, 0..depth
// BEHAVIOUR
// - State: circular storage[depth], head ptr, tail ptr (each 0..depth-1), count (0..depth).
//   Pointers wrap from depth-1 to 0; no power-of-two requirement on depth.
// - RST_N low: immediately (asynchronously) head=tail=count=0.
//   OUT_NOTEMPTY=0, OUT_NOTFULL=1, OUT_COUNT=0, OUT_FIRST=0. Storage contents are not reset.
// - Reset mid-operation discards all entries; the first posedge with RST_N high behaves as normal from empty.
// - Flags and OUT_FIRST are combinational from registered state, with no bypass from IN_ENQ.
//   Latency enq->OUT_FIRST is 1 cycle when empty.
// - Per posedge, priority order:
//   1. IN_EN_CLEAR=1: head=tail=count=0; enq/deq in the same cycle are ignored.
//   2. Otherwise:
//      deq_ok = IN_EN_DEQ & (count>0)
//      enq_ok = IN_EN_ENQ & ((count<depth) | (pipelined & IN_EN_DEQ & count==depth))
// - enq_ok: storage[tail] <= IN_ENQ; tail advances with wrap.
// - deq_ok: head advances with wrap.
// - count <= count + enq_ok - deq_ok.
// - Deq when empty: ignored, no state change; a simultaneous enq is still accepted (count 0->1).
// - Enq when full with pipelined=0: ignored, even if deq fires the same cycle.
// - Enq+deq when 0<count<depth: both take effect, count unchanged.
// - depth==1 is legal: the block degenerates to a single register with valid bit
//   (pipelined=1 gives the one-entry pipeline FIFO).
// - OUT_FIRST = storage[head] when count>0, else 0.
// TESTING
// - Reset: assert RST_N=0 mid-cycle with count=2 -> outputs go immediately to
//   NOTEMPTY=0, NOTFULL=1, COUNT=0, FIRST=0.
// - Fill/drain (width=8, depth=3): enq 0x11,0x22,0x33 -> COUNT=3, NOTFULL=0;
//   enq 0x44 is dropped; three deqs return 0x11,0x22,0x33 in order; COUNT=0.
// - Wrap-around (depth=3): 10 interleaved enq/deq of values 1..10 -> output order is 1..10,
//   COUNT never exceeds 3, pointers wrap correctly.
// - Full with simultaneous enq+deq: pipelined=0 -> COUNT goes 3->2 and 0x44 is lost;
//   pipelined=1 -> COUNT stays 3, FIRST becomes 0x22, 0x44 appears after 0x33.
// - Empty edge: deq alone when empty -> no change; enq 0x5A with deq when empty ->
//   COUNT=1 and FIRST=0x5A next cycle.
// - Clear: COUNT=2 with IN_EN_CLEAR=1 and enq 0x77 in the same cycle -> next cycle COUNT=0,
//   FIRST=0, and 0x77 is not stored.

Source files
------------

// File: rtl/mk_sized_fifo.sv
// mk_sized_fifo: parametrised circular-buffer FIFO of `depth` entries of `width` bits.
// Any depth >= 1 is supported; it does not have to be a power of two.
// With pipelined=1, an enqueue is accepted while the FIFO is full
// if a dequeue happens in the same cycle.
//
// Ports:
//   CLK          clock; all state updates on the rising edge
//   RST_N        asynchronous active-low reset; empties the FIFO
//   IN_ENQ       data to enqueue (max(width,1) bits)
//   IN_EN_ENQ    enqueue strobe
//   IN_EN_DEQ    dequeue strobe
//   IN_EN_CLEAR  synchronous clear; overrides enqueue and dequeue
//   OUT_FIRST    head entry, 0 when empty (combinational from state)
//   OUT_NOTFULL  count < depth
//   OUT_NOTEMPTY count > 0
//   OUT_COUNT    current occupancy, 0..depth
module mk_sized_fifo #(
  parameter int unsigned width     = 1,
  parameter int unsigned depth     = 2,
  parameter int unsigned pipelined = 0,
  localparam int unsigned DW = (width == 0) ? 1 : width,
  localparam int unsigned CW = $clog2(depth + 1),
  localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] IN_ENQ,
  input  logic          IN_EN_ENQ,
  input  logic          IN_EN_DEQ,
  input  logic          IN_EN_CLEAR,
  output logic [DW-1:0] OUT_FIRST,
  output logic          OUT_NOTFULL,
  output logic          OUT_NOTEMPTY,
  output logic [CW-1:0] OUT_COUNT
);

  logic [DW-1:0] storage [depth];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic full;
  logic empty;
  logic deq_ok;
  logic enq_ok;

  // Pointer advance with wrap at depth-1.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : PW'(p + PW'(1));
  endfunction

  // Accept conditions; when full, count>0 so a strobed dequeue always fires.
  always_comb begin
    full   = (count == CW'(depth));
    empty  = (count == '0);
    deq_ok = IN_EN_DEQ & ~empty;
    enq_ok = IN_EN_ENQ & (~full | ((pipelined != 0) & IN_EN_DEQ));
  end

  // Pointers and occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (IN_EN_CLEAR) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (deq_ok) head <= ptr_inc(head);
      if (enq_ok) tail <= ptr_inc(tail);
      count <= CW'(count + CW'(enq_ok) - CW'(deq_ok));
    end
  end

  // Entry storage is intentionally not reset; count gates visibility.
  always_ff @(posedge CLK) begin
    if (!IN_EN_CLEAR && enq_ok) storage[tail] <= IN_ENQ;
  end

  // Head entry is masked to zero when empty or when the FIFO carries no data.
  always_comb begin
    OUT_FIRST    = (!empty && width != 0) ? storage[head] : '0;
    OUT_NOTFULL  = ~full;
    OUT_NOTEMPTY = ~empty;
    OUT_COUNT    = count;
  end

endmodule
